seq_div: RTL

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 20 ++
 rtl/seq_div.sv | 134 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding and the default operand width.
package div_pkg;

  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in next dividend bit, trial-subtract divisor.
// Zero latency; no flow control.
module div_step #(
  parameter int M = div_pkg::DIV_W
) (
  input  logic [M-1:0] i_rem,
  input  logic         i_bit,
  input  logic [M-1:0] i_div,
  output logic [M-1:0] o_rem,
  output logic         o_q
);

  logic [M:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= {1'b0, i_div});
  // When the subtract succeeds the true difference is below the divisor, so the low M bits are exact.
  assign o_rem   = o_q ? (w_shift[M-1:0] - i_div) : w_shift[M-1:0];

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider: M restoring steps, done pulses M+1 cycles after start accept; start only honoured in IDLE.
// SEQ_DIV_ZERO_FAST_EN: divide-by-zero skips RUN and completes one cycle after accept.
module seq_div
  import div_pkg::*;
#(
  parameter int M = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] Q,
  output logic [M-1:0] R,
  output logic         C,
  output logic         N,
  output logic         V,
  output logic         Z
);

  localparam int CW = $clog2(M) + 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  div_state_t   r_state;
  logic [M-1:0] r_dvd;
  logic [M-1:0] r_rem;
  logic [M-1:0] r_b;
  logic [CW-1:0] r_cnt;
  logic         r_busy;
  logic         r_done;
  logic [M-1:0] r_q;
  logic [M-1:0] r_r;
  logic         r_c;
  logic         r_n;
  logic         r_v;
  logic         r_z;

  logic [M-1:0] w_rem;
  logic         w_qbit;
  logic [M-1:0] w_q;

  div_step #(.M(M)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[M-1]),
    .i_div (r_b),
    .o_rem (w_rem),
    .o_q   (w_qbit)
  );

  // Quotient bits fill the dividend register from the bottom as dividend bits leave the top.
  assign w_q = {r_dvd[M-2:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_c     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd <= A;
            r_b   <= B;
            r_rem <= '0;
            r_cnt <= '0;
            r_busy <= 1'b1;
`ifdef SEQ_DIV_ZERO_FAST_EN
            if (B == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_q     <= '1;
              r_r     <= A;
              r_z     <= 1'b0;
              r_n     <= 1'b1;
              r_c     <= (A != '0);
              r_v     <= 1'b1;
            end else begin
              r_state <= RUN;
            end
`else
            r_state <= RUN;
`endif
          end
        end
        RUN: begin
          r_rem <= w_rem;
          r_dvd <= w_q;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_q     <= w_q;
            r_r     <= w_rem;
            r_z     <= (w_q == '0);
            r_n     <= w_q[M-1];
            r_c     <= (w_rem != '0);
            r_v     <= (r_b == '0);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Q    = r_q;
  assign R    = r_r;
  assign C    = r_c;
  assign N    = r_n;
  assign V    = r_v;
  assign Z    = r_z;

endmodule
